// File: rtl/hazard_scoreboard.sv
// Stall/hazard controller beside the D stage: tracks {dest, Tnew} of in-flight
// instructions from E onward and a mult/div busy counter.
module hazard_scoreboard #(
  parameter int NSTAGE   = 3,
  parameter int TW       = 2,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CW       = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4:0]            D_rs,
  input  logic [4:0]            D_rt,
  input  logic [TW-1:0]         D_tuse_rs,
  input  logic [TW-1:0]         D_tuse_rt,
  input  logic [4:0]            D_a3,
  input  logic [TW-1:0]         D_tnew,
  input  logic                  D_md_start,
  input  logic                  D_md_div,
  input  logic                  D_md_use,
  input  logic                  flush,
  output logic                  stall,
  output logic                  e_bubble,
  output logic                  md_busy,
  output logic [5*NSTAGE-1:0]   trk_a3,
  output logic [TW*NSTAGE-1:0]  trk_tnew
);

  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_LAT);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_LAT);

  logic [4:0]    a3_p   [NSTAGE];
  logic [TW-1:0] tnew_p [NSTAGE];
  logic [CW-1:0] md_cnt;
  logic          stall_reg;
  logic          stall_md;
  logic          issue;

  function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] v);
    return (v == '0) ? '0 : v - TW'(1);
  endfunction

  function automatic logic hz(input logic [4:0]    src,
                              input logic [TW-1:0] tuse,
                              input logic [4:0]    a3,
                              input logic [TW-1:0] tnew);
    return (src != 5'd0) && (src == a3) && (tuse < tnew);
  endfunction

  // Hazard detection against every tracked stage (combinational, D stage)
  always_comb begin
    stall_reg = 1'b0;
    for (int k = 0; k < NSTAGE; k++) begin
      stall_reg = stall_reg
                | hz(D_rs, D_tuse_rs, a3_p[k], tnew_p[k])
                | hz(D_rt, D_tuse_rt, a3_p[k], tnew_p[k]);
    end
  end

  assign md_busy  = (md_cnt != '0);
  assign stall_md = (D_md_start | D_md_use) & md_busy;
  // Flush and reset both override any hazard: the D instruction is discarded anyway.
  assign stall    = (stall_reg | stall_md) & ~flush & ~reset;
  assign e_bubble = stall | flush;
  assign issue    = ~stall & ~flush;

  // Tracker shift: E loads the issuing instruction or a bubble, later stages age
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NSTAGE; k++) begin
        a3_p[k]   <= 5'd0;
        tnew_p[k] <= '0;
      end
    end else begin
      a3_p[0]   <= issue ? D_a3   : 5'd0;
      tnew_p[0] <= issue ? D_tnew : '0;
      for (int k = 1; k < NSTAGE; k++) begin
        a3_p[k]   <= flush ? 5'd0 : a3_p[k-1];
        tnew_p[k] <= flush ? '0   : dec_sat(tnew_p[k-1]);
      end
    end
  end

  // Mult/div busy counter; a running operation survives a flush
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt <= '0;
    end else if (D_md_start & issue) begin
      md_cnt <= D_md_div ? DIV_LOAD : MULT_LOAD;
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - CW'(1);
    end
  end

  always_comb begin
    trk_a3   = '0;
    trk_tnew = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      trk_a3[5*k +: 5]     = a3_p[k];
      trk_tnew[TW*k +: TW] = tnew_p[k];
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: stimulus pushes hand-computed
// expectations into a queue, a negedge monitor pops and compares.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  d_rs, d_rt, d_a3;
  logic [1:0]  d_tuse_rs, d_tuse_rt, d_tnew;
  logic        d_md_start, d_md_div, d_md_use, flush;
  logic        stall, e_bubble, md_busy;
  logic [14:0] trk_a3;
  logic [5:0]  trk_tnew;

  typedef struct {
    int          id;
    logic        stall;
    logic        bub;
    logic        busy;
    logic        chk_trk;
    logic [14:0] ta3;
    logic [5:0]  ttn;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   vec_id   = 0;

  hazard_scoreboard #(.NSTAGE(3), .TW(2), .MULT_LAT(5), .DIV_LAT(10), .CW(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .D_rs       (d_rs),
    .D_rt       (d_rt),
    .D_tuse_rs  (d_tuse_rs),
    .D_tuse_rt  (d_tuse_rt),
    .D_a3       (d_a3),
    .D_tnew     (d_tnew),
    .D_md_start (d_md_start),
    .D_md_div   (d_md_div),
    .D_md_use   (d_md_use),
    .flush      (flush),
    .stall      (stall),
    .e_bubble   (e_bubble),
    .md_busy    (md_busy),
    .trk_a3     (trk_a3),
    .trk_tnew   (trk_tnew)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int id, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) $display("FAIL vec%0d %s: got %0h want %0h", id, nm, got, want);
    else n_pass++;
  endtask

  // One cycle of D-stage inputs plus the outputs expected during that cycle
  task automatic step(input logic [4:0] rs, input logic [4:0] rt,
                      input logic [1:0] urs, input logic [1:0] urt,
                      input logic [4:0] a3, input logic [1:0] tn,
                      input logic mds, input logic mdd, input logic mdu,
                      input logic fl, input logic rst,
                      input logic es, input logic eb, input logic ck,
                      input logic [14:0] ea3, input logic [5:0] etn);
    @(posedge clk);
    #1;
    d_rs = rs; d_rt = rt; d_tuse_rs = urs; d_tuse_rt = urt;
    d_a3 = a3; d_tnew = tn;
    d_md_start = mds; d_md_div = mdd; d_md_use = mdu;
    flush = fl; reset = rst;
    q.push_back('{vec_id, es, es | fl, eb, ck, ea3, etn});
    vec_id++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall",    e.id, 32'(stall),    32'(e.stall));
        chk("e_bubble", e.id, 32'(e_bubble), 32'(e.bub));
        chk("md_busy",  e.id, 32'(md_busy),  32'(e.busy));
        if (e.chk_trk) begin
          chk("trk_a3",   e.id, 32'(trk_a3),   32'(e.ta3));
          chk("trk_tnew", e.id, 32'(trk_tnew), 32'(e.ttn));
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    reset = 1'b1; flush = 1'b0;
    d_rs = '0; d_rt = '0; d_tuse_rs = '0; d_tuse_rt = '0; d_a3 = '0; d_tnew = '0;
    d_md_start = 1'b0; d_md_div = 1'b0; d_md_use = 1'b0;
    repeat (2) @(posedge clk);

    // Reset held with a hazard-looking D instruction: no stall, tracker empty
    step(8, 0, 0, 0, 8, 2, 0, 0, 0, 0, 1,  0, 0, 1, 15'd0, 6'd0);

    // lw $8 -> addu $9,$8,$8 (tuse 1)
    step(29, 0, 1, 0, 8, 2, 0, 0, 0, 0, 0,  0, 0, 1, 15'd0, 6'd0);
    step(8, 8, 1, 1, 9, 1, 0, 0, 0, 0, 0,   1, 0, 1, 15'd8, 6'd2);
    step(8, 8, 1, 1, 9, 1, 0, 0, 0, 0, 0,   0, 0, 1, 15'd256, 6'd4);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 15'd8201, 6'd1);

    // lw $8 -> beq $8,$0 (tuse 0): two stall cycles
    step(29, 0, 1, 0, 8, 2, 0, 0, 0, 0, 0,  0, 0, 0, 15'd0, 6'd0);
    step(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 15'd0, 6'd0);
    step(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 1, 15'd256, 6'd4);
    step(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 15'd0, 6'd0);

    // mult then mflo: five stall cycles
    step(4, 5, 1, 1, 0, 0, 1, 0, 0, 0, 0,   0, 0, 0, 15'd0, 6'd0);
    for (int i = 0; i < 5; i++)
      step(0, 0, 0, 0, 10, 1, 0, 0, 1, 0, 0, 1, 1, 0, 15'd0, 6'd0);
    step(0, 0, 0, 0, 10, 1, 0, 0, 1, 0, 0,  0, 0, 0, 15'd0, 6'd0);

    // div then mthi: ten stall cycles
    step(4, 5, 1, 1, 0, 0, 1, 1, 0, 0, 0,   0, 0, 0, 15'd0, 6'd0);
    for (int i = 0; i < 10; i++)
      step(6, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 15'd0, 6'd0);
    step(6, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 15'd0, 6'd0);

    // $0 writer then $0 reader: never stalls
    step(1, 2, 1, 1, 0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 15'd0, 6'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 15'd0, 6'd0);

    // Hazard and flush together, then tracker empty
    step(29, 0, 1, 0, 8, 2, 0, 0, 0, 0, 0,  0, 0, 0, 15'd0, 6'd0);
    step(8, 0, 0, 0, 9, 1, 0, 0, 0, 1, 0,   0, 0, 1, 15'd8, 6'd2);
    step(8, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0,   0, 0, 1, 15'd0, 6'd0);

    // mult, then a flushed div while busy: counter keeps running
    step(4, 5, 1, 1, 0, 0, 1, 0, 0, 0, 0,   0, 0, 0, 15'd0, 6'd0);
    step(0, 0, 0, 0, 7, 1, 1, 1, 0, 1, 0,   0, 1, 0, 15'd0, 6'd0);
    step(29, 0, 1, 0, 8, 2, 0, 0, 0, 0, 0,  0, 1, 1, 15'd0, 6'd0);

    // Reset pulse with md_cnt = 3 and a live tracker entry
    step(8, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1,   0, 1, 1, 15'd8, 6'd2);
    step(8, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 1, 15'd0, 6'd0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
